// File: rtl/spi_controller_if.sv
// spi_controller_if
//   Bundles the command/response handshake and the four SPI pins of the
//   ASCON subnode link.
//   slave  : the SPI controller (accepts commands, drives sck/csb/mosi).
//   master : the host side.
//   The host side also drives miso, so a single harness can play both the
//   requester and the subnode.
//   Signals: cmd_valid/cmd_ready/cmd/wr_data  command request and handshake
//            rsp_valid/rsp_data/cmd_error      response and illegal-command flag
//            sck/csb/mosi/miso                 SPI pins
interface spi_controller_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd;
  logic [127:0] wr_data;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         cmd_error;
  logic         sck;
  logic         csb;
  logic         mosi;
  logic         miso;

  modport master (
    output cmd_valid, cmd, wr_data, miso,
    input  cmd_ready, rsp_valid, rsp_data, cmd_error, sck, csb, mosi
  );

  modport slave (
    input  cmd_valid, cmd, wr_data, miso,
    output cmd_ready, rsp_valid, rsp_data, cmd_error, sck, csb, mosi
  );
endinterface

// File: rtl/spi_controller.sv
// spi_controller
//   SPI master for the ASCON accelerator's SPI subnode.  A single accepted
//   command becomes one complete frame: 5 command bits followed by L payload
//   bits, MSB first.  For reads, miso is shifted in on every payload sck fall.
//   Parameters: CLK_DIV  clk cycles per sck half-period (>= 4)
//               CS_GAP   minimum clk cycles csb stays high between frames (>= 1)
//   Ports:      clk      system clock
//               rst_n    asynchronous active-low reset
//               bus      spi_controller_if.slave (handshake, response, SPI pins)
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP + 1) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t         state_reg, state_next;
  logic [DW-1:0]  div_reg, div_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic [7:0]     bit_reg, bit_next;     // index of the bit currently on the wire
  logic [7:0]     len_reg, len_next;     // payload length L
  logic           rd_reg, rd_next;
  logic [132:0]   tx_reg, tx_next;       // remaining frame bits, MSB next out
  logic [127:0]   rx_reg, rx_next;
  logic           sck_reg, sck_next;
  logic           csb_reg, csb_next;
  logic           mosi_reg, mosi_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic           cmd_error_reg, cmd_error_next;

  // Command decode: payload length, legality and the left-aligned frame.
  // Read frames carry zeros in the payload so mosi stays low.
  logic [7:0]   dec_len;
  logic         dec_legal;
  logic [132:0] dec_frame;

  always_comb begin
    dec_len   = 8'd0;
    dec_legal = 1'b1;
    if (bus.cmd[3:0] <= 4'd2)       dec_len = 8'd128;
    else if (bus.cmd[3:0] == 4'd3)  dec_len = 8'd3;
    else if (bus.cmd[3:0] <= 4'd8)  dec_len = 8'd64;
    else                            dec_legal = 1'b0;

    dec_frame          = '0;
    dec_frame[132:128] = bus.cmd;
    if (!bus.cmd[4]) begin
      case (dec_len)
        8'd128:  dec_frame[127:0]   = bus.wr_data;
        8'd64:   dec_frame[127:64]  = bus.wr_data[63:0];
        8'd3:    dec_frame[127:125] = bus.wr_data[2:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    gap_next       = gap_reg;
    bit_next       = bit_reg;
    len_next       = len_reg;
    rd_next        = rd_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    sck_next       = sck_reg;
    csb_next       = csb_reg;
    mosi_next      = mosi_reg;
    rsp_valid_next = 1'b0;
    cmd_error_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (dec_legal) begin
            state_next = SETUP;
            len_next   = dec_len;
            rd_next    = bus.cmd[4];
            mosi_next  = dec_frame[132];
            tx_next    = {dec_frame[131:0], 1'b0};
            rx_next    = '0;
            bit_next   = 8'd0;
            div_next   = '0;
            csb_next   = 1'b0;
          end else begin
            cmd_error_next = 1'b1;
          end
        end
      end

      SETUP: begin
        if (div_reg == DIV_LAST) begin
          state_next = SHIFT;
          div_next   = '0;
          sck_next   = 1'b1;
        end else begin
          div_next = div_reg + DIV_ONE;
        end
      end

      SHIFT: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + DIV_ONE;
        end else begin
          div_next = '0;
          if (sck_reg) begin
            // sck fall: capture read payload, then present the next bit.
            // Once the frame is exhausted tx_reg only holds zeros.
            sck_next = 1'b0;
            if (rd_reg && bit_reg >= 8'd5)
              rx_next = {rx_reg[126:0], bus.miso};
            mosi_next = tx_reg[132];
            tx_next   = {tx_reg[131:0], 1'b0};
          end else if (bit_reg == len_reg + 8'd4) begin
            // End of the last bit's low phase.
            state_next     = GAP;
            csb_next       = 1'b1;
            mosi_next      = 1'b0;
            rsp_valid_next = 1'b1;
            gap_next       = '0;
          end else begin
            sck_next = 1'b1;
            bit_next = bit_reg + 8'd1;
          end
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) state_next = IDLE;
        else                     gap_next   = gap_reg + GAP_ONE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      gap_reg       <= '0;
      bit_reg       <= 8'd0;
      len_reg       <= 8'd0;
      rd_reg        <= 1'b0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      sck_reg       <= 1'b0;
      csb_reg       <= 1'b1;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      cmd_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      gap_reg       <= gap_next;
      bit_reg       <= bit_next;
      len_reg       <= len_next;
      rd_reg        <= rd_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      sck_reg       <= sck_next;
      csb_reg       <= csb_next;
      mosi_reg      <= mosi_next;
      rsp_valid_reg <= rsp_valid_next;
      cmd_error_reg <= cmd_error_next;
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rx_reg;
  assign bus.cmd_error = cmd_error_reg;
  assign bus.sck       = sck_reg;
  assign bus.csb       = csb_reg;
  assign bus.mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Drives commands into spi_controller, plays the SPI subnode on the pins,
//   and checks every response against a register-level model of the subnode.
module tb_spi_controller;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_controller_if bus();

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [3:0] t);
    if (t <= 4'd2) return 128;
    if (t == 4'd3) return 3;
    if (t <= 4'd8) return 64;
    return 0;
  endfunction

  function automatic logic [127:0] mask_of(input int len);
    if (len >= 128) return '1;
    return (128'd1 << len) - 128'd1;
  endfunction

  // Reference model (command-level view) and subnode register file (wire-level view).
  logic [127:0] model_regs [16];
  logic [127:0] sub_regs   [16];
  logic         sub_op_ready = 1'b0;

  // ---------------- subnode ----------------
  int           sub_bits = 0;
  int           sub_len  = 0;
  logic [132:0] sub_shift = '0;
  logic [4:0]   sub_cmd   = '0;
  logic [127:0] sub_word  = '0;
  int           sub_last_bits = 0;
  logic [4:0]   sub_last_cmd  = '0;
  logic [127:0] sub_last_payload = '0;

  always @(posedge bus.sck or posedge bus.csb or negedge bus.csb) begin
    if (bus.csb === 1'b1) begin
      // Frame end: commit only a complete frame.
      bus.miso = 1'b0;
      if (sub_len > 0 && sub_bits == 5 + sub_len) begin
        sub_last_bits    = sub_bits;
        sub_last_cmd     = sub_cmd;
        sub_last_payload = sub_shift[127:0] & mask_of(sub_len);
        if (!sub_cmd[4]) begin
          sub_regs[sub_cmd[3:0]] = sub_last_payload;
          if (sub_cmd[3:0] == 4'd3) sub_op_ready = 1'b1;
        end
      end
      sub_len = 0;
    end else if (bus.sck === 1'b0) begin
      sub_bits  = 0;
      sub_shift = '0;
      sub_len   = 0;
    end else begin
      sub_shift = {sub_shift[131:0], bus.mosi};
      sub_bits++;
      if (sub_bits == 5) begin
        sub_cmd  = sub_shift[4:0];
        sub_len  = len_of(sub_cmd[3:0]);
        sub_word = sub_regs[sub_cmd[3:0]];
      end
      if (sub_bits > 5 && sub_cmd[4] && sub_bits <= 5 + sub_len) begin
        #1 bus.miso = sub_word[sub_len - (sub_bits - 5)];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int           kind;   // 0 write, 1 read, 2 illegal
    logic [4:0]   cmd;
    logic [127:0] exp;
    int           len;
    int           acc;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  int   low_cnt = 0, hi_cnt = 0, last_hi = 0, mosi_glitch = 0;
  bit   ready_in_frame = 1'b0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0;
      hi_cnt = 0;
      ready_in_frame = 1'b0;
    end else begin
      if (bus.rsp_valid || bus.cmd_error) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response rsp_valid=%0b cmd_error=%0b required=none",
                   bus.rsp_valid, bus.cmd_error);
        end else begin
          mon_e = sb.pop_front();
          check_int("rsp_kind_is_error", int'(bus.cmd_error), int'(mon_e.kind == 2));
          if (mon_e.kind == 2 && bus.cmd_error) begin
            check_int("err_latency", cyc - mon_e.acc, 1);
            check_int("err_csb_high", int'(bus.csb), 1);
            check_int("err_sck_low", int'(bus.sck), 0);
          end else if (mon_e.kind != 2 && bus.rsp_valid) begin
            check_int("rsp_latency", cyc - mon_e.acc, 1 + (2 * (5 + mon_e.len) + 1) * CLK_DIV);
            check_int("csb_low_cycles", low_cnt, (2 * (5 + mon_e.len) + 1) * CLK_DIV);
            check_int("sub_frame_bits", sub_last_bits, 5 + mon_e.len);
            check_vec("sub_frame_cmd", 128'(sub_last_cmd), 128'(mon_e.cmd));
            check_int("ready_in_frame", int'(ready_in_frame), 0);
            if (mon_e.kind == 1) begin
              check_vec("rsp_data_read", bus.rsp_data, mon_e.exp);
              check_vec("read_mosi_payload", sub_last_payload, 128'd0);
            end else begin
              check_vec("sub_reg_write", sub_regs[mon_e.cmd[3:0]], mon_e.exp);
              check_vec("rsp_data_write", bus.rsp_data, 128'd0);
            end
          end
        end
      end

      if (!bus.csb) begin
        low_cnt++;
        if (bus.cmd_ready) ready_in_frame = 1'b1;
        if (hi_cnt != 0) last_hi = hi_cnt;
        hi_cnt = 0;
      end else begin
        low_cnt = 0;
        ready_in_frame = 1'b0;
        hi_cnt++;
      end

      if (bus.sck && prev_sck && bus.mosi !== prev_mosi) mosi_glitch++;
      prev_sck  = bus.sck;
      prev_mosi = bus.mosi;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [4:0] c, input logic [127:0] d, input bit hold);
    sb_t e;
    int  t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.wr_data   = d;
    while (!bus.cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cmd=%b actual=not_ready required=ready", c);
      bus.cmd_valid = 1'b0;
      return;
    end
    e.cmd = c;
    e.len = len_of(c[3:0]);
    e.acc = cyc;
    e.exp = '0;
    if (e.len == 0) begin
      e.kind = 2;
    end else if (c[4]) begin
      e.kind = 1;
      e.exp  = model_regs[c[3:0]];
    end else begin
      e.kind = 0;
      e.exp  = d & mask_of(e.len);
      model_regs[c[3:0]] = e.exp;
    end
    sb.push_back(e);
    $display("txn cmd=%b data=%h kind=%0d accept_cycle=%0d", c, d, e.kind, e.acc);
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !bus.cmd_ready) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout pending=%0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [127:0] old_reg1;
  logic [127:0] rnd;
  int           t_wait;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.wr_data   = '0;
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom} & mask_of(len_of(4'(i)));
      model_regs[i] = rnd;
      sub_regs[i]   = rnd;
    end
    model_regs[6] = 128'hDEADBEEF_CAFEF00D;
    sub_regs[6]   = 128'hDEADBEEF_CAFEF00D;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_int("reset_csb", int'(bus.csb), 1);
    check_int("reset_sck", int'(bus.sck), 0);
    check_int("reset_mosi", int'(bus.mosi), 0);
    check_int("reset_cmd_ready", int'(bus.cmd_ready), 1);
    check_int("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check_int("reset_cmd_error", int'(bus.cmd_error), 0);
    check_vec("reset_rsp_data", bus.rsp_data, 128'd0);
    check_int("reset_op_ready", int'(sub_op_ready), 0);

    // Write reg0, read S_2
    issue(5'b00000, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    wait_idle();
    check_vec("reg0_value", sub_regs[0], 128'h0123456789ABCDEF_FEDCBA9876543210);
    issue(5'b10110, 128'h0, 1'b0);
    wait_idle();

    // Op mode round trip
    issue(5'b00011, 128'h5, 1'b0);
    wait_idle();
    check_vec("op_mode_value", sub_regs[3], 128'h5);
    check_int("op_ready", int'(sub_op_ready), 1);
    issue(5'b10011, 128'h0, 1'b0);
    wait_idle();

    // Illegal command
    issue(5'b01001, 128'hFFFF, 1'b0);
    wait_idle();

    // Back-to-back with cmd_valid held
    issue(5'b00010, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    issue(5'b10010, 128'h0, 1'b0);
    wait_idle();
    check_int("b2b_csb_high_cycles", last_hi, CS_GAP + 1);

    // Reset during payload bit 40 of a reg1 write
    old_reg1 = model_regs[1];
    issue(5'b00001, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    t_wait = 0;
    while (sub_bits < 5 + 41 && t_wait < 3000) begin
      @(negedge clk);
      t_wait++;
    end
    check_int("reset_point_reached", int'(sub_bits >= 5 + 41), 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("midreset_csb", int'(bus.csb), 1);
    check_int("midreset_sck", int'(bus.sck), 0);
    check_vec("midreset_rsp_data", bus.rsp_data, 128'd0);
    sb.delete();
    model_regs[1] = old_reg1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("reg1_untouched", sub_regs[1], old_reg1);
    issue(5'b00001, 128'hA5, 1'b0);
    wait_idle();
    check_vec("reg1_after_reset", sub_regs[1], 128'hA5);
    issue(5'b10001, 128'h0, 1'b0);
    wait_idle();

    // Randomized traffic, sometimes back-to-back
    for (int i = 0; i < 16; i++) begin
      issue({1'($urandom_range(0, 1)), 4'($urandom_range(0, 11))},
            {$urandom, $urandom, $urandom, $urandom},
            (i < 15) && ($urandom_range(0, 1) == 1));
    end
    wait_idle();

    check_int("mosi_stable_while_sck_high", mosi_glitch, 0);
    check_int("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (master) for the ASCON accelerator's SPI subnode. It turns a single command request into one complete SPI transaction on sck/csb/mosi, and captures miso for read commands. It sits in the test/host-side harness and in any on-chip sequencer that configures the accelerator: it loads registers, writes the op mode or state words, and reads results back.

## Interface
- CLK_DIV, default 4: clk cycles per sck half-period; legal values ≥ 4.
- CS_GAP, default 4: minimum clk cycles csb stays high between transactions; legal values ≥ 1.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only. A command is accepted on a cycle with cmd_valid & cmd_ready.
- cmd  in  5  subnode command. Bit 4 = read; bits 3:0 = target.
- wr_data  in  128  write payload, LSB-aligned; sampled at acceptance.
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes).
- rsp_data  out  128  read payload, LSB-aligned, upper bits zero. Valid from rsp_valid until the next acceptance.
- cmd_error  out  1  one-cycle pulse for an illegal command.
- sck  out  1  SPI clock, idle low.
- csb  out  1  chip select, active-low.
- mosi  out  1  serial data to the subnode.
- miso  in  1  serial data from the subnode.

## Operation
- Payload length L is decoded from cmd[3:0]:
  - 0, 1, 2 (reg0/1/2): L = 128.
  - 3 (op mode): L = 3.
  - 4–8 (S_0..S_4): L = 64.
  - 9–15: illegal.
- Illegal command: the handshake still completes. cmd_error pulses the next cycle, no SPI activity occurs, rsp_valid does not pulse, and the FSM stays in IDLE.
- Frame: 5 command bits, then L payload bits, all MSB first.
  - Command bits: cmd[4] down to cmd[0].
  - Writes: wr_data[L-1] down to wr_data[0].
  - Reads: mosi = 0 during the payload.
- mosi changes only while sck is low (at csb fall and at each sck fall). The subnode samples mosi on sck rise.
- Read capture: the subnode updates miso after each payload sck rise. The controller samples miso on the following sck fall. The first sample is rsp_data[L-1], shifted in at the LSB; after L samples, rsp_data[L-1:0] holds the word.
- FSM states:
  - IDLE: csb = 1, sck = 0, mosi = 0, cmd_ready = 1. On a legal accept: latch cmd/L/wr_data, clear rsp_data, go to SETUP.
  - SETUP: csb = 0, mosi = first bit. After CLK_DIV cycles, go to SHIFT.
  - SHIFT: for each of the 5+L bits, sck is high for CLK_DIV cycles, then low for CLK_DIV cycles. On each fall: if it is a read payload bit, sample miso; then present the next bit. After the last bit's low phase, go to GAP.
  - GAP: csb = 1, sck = 0; rsp_valid pulses on the first GAP cycle. After CS_GAP cycles, go to IDLE.
- Counters:
  - Bit counter: 8 bits, counts 0..132.
  - Divider: $clog2(CLK_DIV)+1 bits; no wrap-around beyond the terminal count.

## Timing
- Reset values: csb = 1, sck = 0, mosi = 0, cmd_ready = 1, rsp_valid = 0, cmd_error = 0, rsp_data = 0. State = IDLE.
- All outputs are registered except cmd_ready, which is decoded from the state.
- csb falls on the cycle after acceptance.
- csb stays low for exactly (2·(5+L)+1)·CLK_DIV cycles. With CLK_DIV = 4: L = 128 gives 1068 cycles; L = 64 gives 556; L = 3 gives 68.
- First sck rise: CLK_DIV cycles after csb falls. Last sck fall: CLK_DIV cycles before csb rises.
- Accept-to-rsp_valid latency: 1 + (2·(5+L)+1)·CLK_DIV cycles.
- Back-to-back commands: csb high for exactly CS_GAP+1 cycles when cmd_valid is held high.
- cmd_valid, cmd and wr_data are ignored outside IDLE.
- Reset mid-transaction: csb = 1 and sck = 0 asynchronously. Partial rsp_data is cleared, no rsp_valid is issued, and the subnode sees csb rise and resets its own FSM.

## Test plan
- Write reg0: cmd = 00000, wr_data = 128'h0123456789ABCDEF_FEDCBA9876543210, CLK_DIV = 4 → subnode reg0_128b equals wr_data; csb low for 1068 cycles; one rsp_valid pulse.
- Read S_2: cmd = 10110, subnode S_2_reg = 64'hDEADBEEF_CAFEF00D → rsp_data = {64'h0, 64'hDEADBEEF_CAFEF00D}; mosi = 0 throughout the payload.
- Op mode round trip: cmd = 00011, wr_data = 3'b101 → subnode operation_mode = 101 and operation_ready = 1. Then cmd = 10011 → rsp_data = 128'h5.
- Illegal command: cmd = 01001 → cmd_error pulses once; csb stays 1; no sck edges; rsp_valid stays 0.
- Back-to-back: two commands with cmd_valid held high, CS_GAP = 4 → cmd_ready low throughout transaction 1; csb high exactly 5 cycles between the frames; both complete correctly.
- Reset during payload bit 40 of a reg1 write → csb = 1 and sck = 0 immediately. After release, a fresh reg1 write of 128'hA5 produces subnode reg1_128b = 128'hA5.
